// File: rtl/l1_cpu_responder_pkg.sv
// Shared types and sizes for the L1 CPU responder: MESI line states,
// bus commands, controller states and the snoop state-transition helper.
package l1_cpu_responder_pkg;

    localparam int XLEN           = 32;
    localparam int CACHELINE_SIZE = 64;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_t;

    typedef enum logic [1:0] {
        BUS_RD   = 2'd0,
        BUS_RDX  = 2'd1,
        BUS_UPGR = 2'd2,
        BUS_WB   = 2'd3
    } bus_cmd_t;

    typedef enum logic [2:0] {
        L1_IDLE    = 3'd0,
        L1_LOOKUP  = 3'd1,
        L1_BUSREQ  = 3'd2,
        L1_BUSWAIT = 3'd3,
        L1_RESP    = 3'd4
    } l1_state_t;

    // New MESI state of a line that hits another core's bus transaction.
    function automatic mesi_t snoop_next_state(input mesi_t cur, input bus_cmd_t cmd);
        mesi_t nxt;
        nxt = cur;
        case (cmd)
            BUS_RD:   nxt = ((cur == MESI_M) || (cur == MESI_E)) ? MESI_S : cur;
            BUS_RDX:  nxt = MESI_I;
            BUS_UPGR: nxt = (cur == MESI_S) ? MESI_I : cur;
            default:  nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/l1_cpu_responder_line_array.sv
// Direct-mapped tag/MESI/data storage. One registered write port for the
// controller, a combinational lookup port and a combinational snoop port
// whose state update is applied at the clock edge. When both touch the same
// index in one cycle the controller write takes precedence.
module l1_cpu_responder_line_array
    import l1_cpu_responder_pkg::*;
#(
    parameter int NUM_SETS = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wr_en,
    input  logic [$clog2(NUM_SETS)-1:0]           wr_idx,
    input  logic [XLEN-$clog2(NUM_SETS)-1:0]      wr_tag,
    input  mesi_t                                 wr_state,
    input  logic [CACHELINE_SIZE-1:0]             wr_data,
    input  logic [$clog2(NUM_SETS)-1:0]           lk_idx,
    output logic [XLEN-$clog2(NUM_SETS)-1:0]      lk_tag,
    output mesi_t                                 lk_state,
    output logic [CACHELINE_SIZE-1:0]             lk_data,
    input  logic                                  sn_valid,
    input  bus_cmd_t                              sn_cmd,
    input  logic [XLEN-1:0]                       sn_addr,
    output logic                                  sn_hit,
    output logic                                  sn_dirty,
    output logic [CACHELINE_SIZE-1:0]             sn_data
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = XLEN - IDX_W;

    logic [TAG_W-1:0]          tag_r  [NUM_SETS];
    mesi_t                     mesi_r [NUM_SETS];
    logic [CACHELINE_SIZE-1:0] data_r [NUM_SETS];

    logic [IDX_W-1:0] sn_idx_s;
    logic [TAG_W-1:0] sn_tag_s;
    logic             sn_apply_s;

    assign sn_idx_s = sn_addr[IDX_W-1:0];
    assign sn_tag_s = sn_addr[XLEN-1:IDX_W];

    // Lookup port: raw contents of the selected set.
    always_comb begin
        lk_tag   = tag_r[lk_idx];
        lk_state = mesi_r[lk_idx];
        lk_data  = data_r[lk_idx];
    end

    // Snoop port: hit/dirty/data for the snooped address, data zero on a miss.
    always_comb begin
        sn_hit   = (mesi_r[sn_idx_s] != MESI_I) && (tag_r[sn_idx_s] == sn_tag_s);
        sn_dirty = sn_hit && (mesi_r[sn_idx_s] == MESI_M);
        if (sn_hit) begin
            sn_data = data_r[sn_idx_s];
        end else begin
            sn_data = {CACHELINE_SIZE{1'b0}};
        end
        sn_apply_s = sn_valid && sn_hit && !(wr_en && (wr_idx == sn_idx_s));
    end

    // Storage update: controller write plus snoop state change on other sets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                tag_r[i]  <= {TAG_W{1'b0}};
                mesi_r[i] <= MESI_I;
                data_r[i] <= {CACHELINE_SIZE{1'b0}};
            end
        end else begin
            if (wr_en) begin
                tag_r[wr_idx]  <= wr_tag;
                mesi_r[wr_idx] <= wr_state;
                data_r[wr_idx] <= wr_data;
            end
            if (sn_apply_s) begin
                mesi_r[sn_idx_s] <= snoop_next_state(mesi_r[sn_idx_s], sn_cmd);
            end
        end
    end

endmodule

// File: rtl/l1_cpu_responder.sv
// L1 CPU responder: direct-mapped MESI cache controller between one core
// and the shared atomic bus. Serves hits locally, issues BusRd/BusRdX/
// BusUpgr/BusWB on misses and upgrades, and answers snoops combinationally.
// Optional build macro L1_STATS_EN adds saturating hit/miss counters.
module l1_cpu_responder
    import l1_cpu_responder_pkg::*;
#(
    parameter int ID       = 0,
    parameter int NUM_SETS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [XLEN-1:0]           cpu_addr,
    input  logic [CACHELINE_SIZE-1:0] cpu_wdata,
    output logic                      cpu_ready,
    output logic                      cpu_resp,
    output logic [CACHELINE_SIZE-1:0] cpu_rdata,
    output logic                      bus_req,
    output bus_cmd_t                  bus_cmd,
    output logic [XLEN-1:0]           bus_addr,
    output logic [CACHELINE_SIZE-1:0] bus_wdata,
    input  logic                      bus_grant,
    input  logic                      bus_resp,
    input  logic [CACHELINE_SIZE-1:0] bus_rdata,
    input  logic                      bus_shared,
    input  logic                      snoop_valid,
    input  bus_cmd_t                  snoop_cmd,
    input  logic [XLEN-1:0]           snoop_addr,
    output logic                      snoop_hit,
    output logic                      snoop_dirty,
    output logic [CACHELINE_SIZE-1:0] snoop_data
`ifdef L1_STATS_EN
    ,
    output logic [31:0]               hit_count,
    output logic [31:0]               miss_count
`endif
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = XLEN - IDX_W;

    if ((NUM_SETS < 2) || ((NUM_SETS & (NUM_SETS - 1)) != 0)) begin : g_bad_num_sets
        $error("l1_cpu_responder %0d: NUM_SETS must be a power of 2", ID);
    end

    l1_state_t                 state_r, state_n;
    logic                      we_r, we_n;
    logic [XLEN-1:0]           addr_r, addr_n;
    logic [CACHELINE_SIZE-1:0] wdata_r, wdata_n;
    logic                      cpu_ready_n, cpu_resp_n, bus_req_n;
    logic [CACHELINE_SIZE-1:0] cpu_rdata_n, bus_wdata_n;
    bus_cmd_t                  bus_cmd_n;
    logic [XLEN-1:0]           bus_addr_n;

    logic [IDX_W-1:0]          idx_s;
    logic [TAG_W-1:0]          tag_s;
    logic                      wr_en_s;
    logic [TAG_W-1:0]          wr_tag_s;
    mesi_t                     wr_state_s;
    logic [CACHELINE_SIZE-1:0] wr_data_s;
    logic [TAG_W-1:0]          lk_tag_s;
    mesi_t                     lk_state_s;
    logic [CACHELINE_SIZE-1:0] lk_data_s;
    logic                      lk_hit_s, snoop_conflict_s, upgr_lost_s;
    logic                      hit_inc_s, miss_inc_s;

    assign idx_s = addr_r[IDX_W-1:0];
    assign tag_s = addr_r[XLEN-1:IDX_W];

    l1_cpu_responder_line_array #(.NUM_SETS(NUM_SETS)) u_lines (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en_s),
        .wr_idx   (idx_s),
        .wr_tag   (wr_tag_s),
        .wr_state (wr_state_s),
        .wr_data  (wr_data_s),
        .lk_idx   (idx_s),
        .lk_tag   (lk_tag_s),
        .lk_state (lk_state_s),
        .lk_data  (lk_data_s),
        .sn_valid (snoop_valid),
        .sn_cmd   (snoop_cmd),
        .sn_addr  (snoop_addr),
        .sn_hit   (snoop_hit),
        .sn_dirty (snoop_dirty),
        .sn_data  (snoop_data)
    );

    // Next-state, line-array write and registered-output decode.
    always_comb begin
        state_n     = state_r;
        we_n        = we_r;
        addr_n      = addr_r;
        wdata_n     = wdata_r;
        cpu_resp_n  = 1'b0;
        cpu_rdata_n = {CACHELINE_SIZE{1'b0}};
        bus_req_n   = bus_req;
        bus_cmd_n   = bus_cmd;
        bus_addr_n  = bus_addr;
        bus_wdata_n = bus_wdata;
        wr_en_s     = 1'b0;
        wr_tag_s    = tag_s;
        wr_state_s  = MESI_I;
        wr_data_s   = wdata_r;
        hit_inc_s   = 1'b0;
        miss_inc_s  = 1'b0;

        lk_hit_s         = (lk_state_s != MESI_I) && (lk_tag_s == tag_s);
        snoop_conflict_s = snoop_valid && (snoop_addr[IDX_W-1:0] == idx_s);
        // Another core took ownership of the line we are waiting to upgrade.
        upgr_lost_s      = snoop_valid && (snoop_addr == addr_r) &&
                           ((snoop_cmd == BUS_RDX) || (snoop_cmd == BUS_UPGR));

        case (state_r)
            L1_IDLE: begin
                if (cpu_req) begin
                    we_n    = cpu_we;
                    addr_n  = cpu_addr;
                    wdata_n = cpu_wdata;
                    state_n = L1_LOOKUP;
                end else begin
                    state_n = L1_IDLE;
                end
            end
            L1_LOOKUP: begin
                if (snoop_conflict_s) begin
                    // Let the snoop settle the set before deciding.
                    state_n = L1_LOOKUP;
                end else if (lk_hit_s && !we_r) begin
                    hit_inc_s   = 1'b1;
                    cpu_resp_n  = 1'b1;
                    cpu_rdata_n = lk_data_s;
                    state_n     = L1_RESP;
                end else if (lk_hit_s && (lk_state_s == MESI_S)) begin
                    miss_inc_s  = 1'b1;
                    bus_req_n   = 1'b1;
                    bus_cmd_n   = BUS_UPGR;
                    bus_addr_n  = addr_r;
                    bus_wdata_n = {CACHELINE_SIZE{1'b0}};
                    state_n     = L1_BUSREQ;
                end else if (lk_hit_s) begin
                    hit_inc_s  = 1'b1;
                    wr_en_s    = 1'b1;
                    wr_state_s = MESI_M;
                    cpu_resp_n = 1'b1;
                    state_n    = L1_RESP;
                end else if (lk_state_s == MESI_M) begin
                    miss_inc_s  = 1'b1;
                    bus_req_n   = 1'b1;
                    bus_cmd_n   = BUS_WB;
                    bus_addr_n  = {lk_tag_s, idx_s};
                    bus_wdata_n = lk_data_s;
                    state_n     = L1_BUSREQ;
                end else begin
                    miss_inc_s  = 1'b1;
                    bus_req_n   = 1'b1;
                    bus_cmd_n   = we_r ? BUS_RDX : BUS_RD;
                    bus_addr_n  = addr_r;
                    bus_wdata_n = {CACHELINE_SIZE{1'b0}};
                    state_n     = L1_BUSREQ;
                end
            end
            L1_BUSREQ: begin
                if ((bus_cmd == BUS_UPGR) && upgr_lost_s) begin
                    bus_cmd_n = BUS_RDX;
                end else begin
                    bus_cmd_n = bus_cmd;
                end
                if (bus_grant) begin
                    bus_req_n = 1'b0;
                    state_n   = L1_BUSWAIT;
                end else begin
                    state_n   = L1_BUSREQ;
                end
            end
            L1_BUSWAIT: begin
                if (bus_resp) begin
                    case (bus_cmd)
                        BUS_WB: begin
                            wr_en_s     = 1'b1;
                            wr_tag_s    = lk_tag_s;
                            wr_state_s  = MESI_I;
                            wr_data_s   = lk_data_s;
                            bus_req_n   = 1'b1;
                            bus_cmd_n   = we_r ? BUS_RDX : BUS_RD;
                            bus_addr_n  = addr_r;
                            bus_wdata_n = {CACHELINE_SIZE{1'b0}};
                            state_n     = L1_BUSREQ;
                        end
                        BUS_RD: begin
                            wr_en_s     = 1'b1;
                            wr_state_s  = bus_shared ? MESI_S : MESI_E;
                            wr_data_s   = bus_rdata;
                            cpu_resp_n  = 1'b1;
                            cpu_rdata_n = bus_rdata;
                            state_n     = L1_RESP;
                        end
                        BUS_RDX, BUS_UPGR: begin
                            wr_en_s    = 1'b1;
                            wr_state_s = MESI_M;
                            cpu_resp_n = 1'b1;
                            state_n    = L1_RESP;
                        end
                        default: begin
                            state_n = L1_IDLE;
                        end
                    endcase
                end else begin
                    state_n = L1_BUSWAIT;
                end
            end
            L1_RESP: begin
                state_n = L1_IDLE;
            end
            default: begin
                state_n = L1_IDLE;
            end
        endcase

        cpu_ready_n = (state_n == L1_IDLE);
    end

    // Controller state, latched request and registered CPU/bus outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= L1_IDLE;
            we_r      <= 1'b0;
            addr_r    <= {XLEN{1'b0}};
            wdata_r   <= {CACHELINE_SIZE{1'b0}};
            cpu_ready <= 1'b1;
            cpu_resp  <= 1'b0;
            cpu_rdata <= {CACHELINE_SIZE{1'b0}};
            bus_req   <= 1'b0;
            bus_cmd   <= BUS_RD;
            bus_addr  <= {XLEN{1'b0}};
            bus_wdata <= {CACHELINE_SIZE{1'b0}};
        end else begin
            state_r   <= state_n;
            we_r      <= we_n;
            addr_r    <= addr_n;
            wdata_r   <= wdata_n;
            cpu_ready <= cpu_ready_n;
            cpu_resp  <= cpu_resp_n;
            cpu_rdata <= cpu_rdata_n;
            bus_req   <= bus_req_n;
            bus_cmd   <= bus_cmd_n;
            bus_addr  <= bus_addr_n;
            bus_wdata <= bus_wdata_n;
        end
    end

`ifdef L1_STATS_EN
    // Saturating hit/miss counters stepped by the lookup decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            if (hit_inc_s && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss_inc_s && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_l1_cpu_responder.sv
// Self-checking bench for l1_cpu_responder: expected CPU responses and bus
// transactions are queued when a request is driven and popped as the DUT
// produces them; line states are probed through the combinational snoop port.
module tb_l1_cpu_responder;
    import l1_cpu_responder_pkg::*;

    localparam int CL = CACHELINE_SIZE;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cpu_req = 1'b0;
    logic            cpu_we = 1'b0;
    logic [XLEN-1:0] cpu_addr = '0;
    logic [CL-1:0]   cpu_wdata = '0;
    logic            cpu_ready, cpu_resp;
    logic [CL-1:0]   cpu_rdata;
    logic            bus_req;
    bus_cmd_t        bus_cmd;
    logic [XLEN-1:0] bus_addr;
    logic [CL-1:0]   bus_wdata;
    logic            bus_grant = 1'b0;
    logic            bus_resp = 1'b0;
    logic [CL-1:0]   bus_rdata = '0;
    logic            bus_shared = 1'b0;
    logic            snoop_valid = 1'b0;
    bus_cmd_t        snoop_cmd = BUS_RD;
    logic [XLEN-1:0] snoop_addr = '0;
    logic            snoop_hit, snoop_dirty;
    logic [CL-1:0]   snoop_data;
`ifdef L1_STATS_EN
    logic [31:0]     hit_count, miss_count;
`endif

    int errors = 0;
    int checks = 0;

    logic [CL-1:0]   exp_rdata_q[$];
    bus_cmd_t        exp_cmd_q[$];
    logic [XLEN-1:0] exp_addr_q[$];
    logic [CL-1:0]   exp_wdata_q[$];

    l1_cpu_responder #(.ID(0), .NUM_SETS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ready   (cpu_ready),
        .cpu_resp    (cpu_resp),
        .cpu_rdata   (cpu_rdata),
        .bus_req     (bus_req),
        .bus_cmd     (bus_cmd),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_grant   (bus_grant),
        .bus_resp    (bus_resp),
        .bus_rdata   (bus_rdata),
        .bus_shared  (bus_shared),
        .snoop_valid (snoop_valid),
        .snoop_cmd   (snoop_cmd),
        .snoop_addr  (snoop_addr),
        .snoop_hit   (snoop_hit),
        .snoop_dirty (snoop_dirty),
        .snoop_data  (snoop_data)
`ifdef L1_STATS_EN
        ,
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic push_bus(input bus_cmd_t cmd, input logic [XLEN-1:0] addr, input logic [CL-1:0] wdata);
        exp_cmd_q.push_back(cmd);
        exp_addr_q.push_back(addr);
        exp_wdata_q.push_back(wdata);
    endtask

    // Passive line-state probe (snoop_valid low, so no state change).
    task automatic probe(input logic [XLEN-1:0] addr, input logic eh, input logic ed,
                         input logic [CL-1:0] edata, input string name);
        snoop_valid = 1'b0;
        snoop_addr  = addr;
        #1;
        checks++;
        if ({snoop_hit, snoop_dirty} !== {eh, ed}) begin
            errors++;
            $display("FAIL %s hit/dirty: got %b%b want %b%b", name, snoop_hit, snoop_dirty, eh, ed);
        end
        checks++;
        if (snoop_data !== edata) begin
            errors++;
            $display("FAIL %s data: got %h want %h", name, snoop_data, edata);
        end
    endtask

    // One snoop cycle from another core; checks the combinational answer.
    task automatic snoop_cycle(input bus_cmd_t cmd, input logic [XLEN-1:0] addr, input logic eh,
                               input logic ed, input logic [CL-1:0] edata, input string name);
        snoop_valid = 1'b1;
        snoop_cmd   = cmd;
        snoop_addr  = addr;
        #1;
        checks++;
        if ({snoop_hit, snoop_dirty, snoop_data} !== {eh, ed, edata}) begin
            errors++;
            $display("FAIL %s: got hit=%b dirty=%b data=%h want hit=%b dirty=%b data=%h",
                     name, snoop_hit, snoop_dirty, snoop_data, eh, ed, edata);
        end
        @(posedge clk);
        @(negedge clk);
        snoop_valid = 1'b0;
    endtask

    // Drive one CPU request and act as the bus arbiter/memory until cpu_resp.
    task automatic access(input logic we, input logic [XLEN-1:0] addr, input logic [CL-1:0] wdata,
                          input logic [CL-1:0] fill, input logic shared, input logic [CL-1:0] exp_rdata,
                          input int exp_lat, input logic inject, input string name);
        int       cyc;
        bit       done;
        bit       granted;
        logic     inj;
        logic [CL-1:0]   e_rd;
        bus_cmd_t        e_cmd;
        logic [XLEN-1:0] e_addr;
        logic [CL-1:0]   e_wd;
        cyc = 0; done = 1'b0; granted = 1'b0; inj = inject;
        exp_rdata_q.push_back(exp_rdata);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        while (!done && cyc < 60) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            bus_grant = 1'b0; bus_resp = 1'b0; bus_shared = 1'b0;
            bus_rdata = '0; snoop_valid = 1'b0;
            if (cpu_resp) begin
                e_rd = exp_rdata_q.pop_front();
                checks++;
                if (cpu_rdata !== e_rd) begin
                    errors++;
                    $display("FAIL %s rdata: got %h want %h", name, cpu_rdata, e_rd);
                end
                if (exp_lat >= 0) begin
                    checks++;
                    if (cyc != exp_lat) begin
                        errors++;
                        $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
                    end
                end
                checks++;
                if (cpu_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s ready_in_resp: got %b want 0", name, cpu_ready);
                end
                cpu_req = 1'b0;
                done = 1'b1;
            end else if (granted) begin
                bus_resp = 1'b1; bus_rdata = fill; bus_shared = shared;
                granted = 1'b0;
            end else if (bus_req) begin
                checks++;
                if (exp_cmd_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected_bus_req: got cmd=%0d addr=%h want none", name, bus_cmd, bus_addr);
                    bus_grant = 1'b1; granted = 1'b1;
                end else begin
                    e_cmd = exp_cmd_q.pop_front();
                    e_addr = exp_addr_q.pop_front();
                    e_wd = exp_wdata_q.pop_front();
                    if ({bus_cmd, bus_addr, bus_wdata} !== {e_cmd, e_addr, e_wd}) begin
                        errors++;
                        $display("FAIL %s bus: got cmd=%0d addr=%h wdata=%h want cmd=%0d addr=%h wdata=%h",
                                 name, bus_cmd, bus_addr, bus_wdata, e_cmd, e_addr, e_wd);
                    end
                    if (inj) begin
                        snoop_valid = 1'b1; snoop_cmd = BUS_RDX; snoop_addr = addr;
                        inj = 1'b0;
                    end else begin
                        bus_grant = 1'b1; granted = 1'b1;
                    end
                end
            end
        end
        if (!done) begin
            errors++; checks++;
            $display("FAIL %s timeout: got no cpu_resp want one within 60 cycles", name);
            cpu_req = 1'b0;
            exp_rdata_q.delete();
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cpu_resp, cpu_ready} !== 2'b01) begin
            errors++;
            $display("FAIL %s after_resp: got resp=%b ready=%b want resp=0 ready=1", name, cpu_resp, cpu_ready);
        end
        checks++;
        if (exp_cmd_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing_bus: got %0d unissued want 0", name, exp_cmd_q.size());
            exp_cmd_q.delete(); exp_addr_q.delete(); exp_wdata_q.delete();
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({cpu_ready, cpu_resp, bus_req} !== 3'b100 || cpu_rdata !== '0 || bus_cmd !== BUS_RD ||
            bus_addr !== '0 || bus_wdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b resp=%b req=%b cmd=%0d addr=%h rdata=%h wdata=%h",
                     cpu_ready, cpu_resp, bus_req, bus_cmd, bus_addr, cpu_rdata, bus_wdata);
        end
        probe(32'd5, 1'b0, 1'b0, 64'h0, "reset_line5");
    endtask

    task automatic test_cold_and_hit_read();
        push_bus(BUS_RD, 32'd5, 64'h0);
        access(1'b0, 32'd5, 64'h0, 64'hAA, 1'b0, 64'hAA, 4, 1'b0, "cold_read5");
        probe(32'd5, 1'b1, 1'b0, 64'hAA, "line5_E");
        access(1'b0, 32'd5, 64'h0, 64'h0, 1'b0, 64'hAA, 2, 1'b0, "hit_read5");
    endtask

    task automatic test_upgrade();
        snoop_cycle(BUS_RD, 32'd5, 1'b1, 1'b0, 64'hAA, "snoop_rd5_E");
        push_bus(BUS_UPGR, 32'd5, 64'h0);
        access(1'b1, 32'd5, 64'h11, 64'h0, 1'b0, 64'h0, 4, 1'b0, "upgr_write5");
        probe(32'd5, 1'b1, 1'b1, 64'h11, "line5_M");
        access(1'b0, 32'd5, 64'h0, 64'h0, 1'b0, 64'h11, 2, 1'b0, "read5_after_upgr");
    endtask

    task automatic test_writeback();
        push_bus(BUS_WB, 32'd5, 64'h11);
        push_bus(BUS_RD, 32'd13, 64'h0);
        access(1'b0, 32'd13, 64'h0, 64'hBB, 1'b0, 64'hBB, 6, 1'b0, "wb_then_rd13");
        probe(32'd5, 1'b0, 1'b0, 64'h0, "line5_evicted");
        probe(32'd13, 1'b1, 1'b0, 64'hBB, "line13_E");
        access(1'b1, 32'd13, 64'h22, 64'h0, 1'b0, 64'h0, 2, 1'b0, "silent_write13");
    endtask

    task automatic test_snoop();
        snoop_cycle(BUS_RD, 32'd13, 1'b1, 1'b1, 64'h22, "snoop_rd13_M");
        probe(32'd13, 1'b1, 1'b0, 64'h22, "line13_S");
        snoop_cycle(BUS_RDX, 32'd13, 1'b1, 1'b0, 64'h22, "snoop_rdx13_S");
        probe(32'd13, 1'b0, 1'b0, 64'h0, "line13_I");
        push_bus(BUS_RD, 32'd13, 64'h0);
        access(1'b0, 32'd13, 64'h0, 64'h33, 1'b1, 64'h33, 4, 1'b0, "reread13_shared");
        push_bus(BUS_UPGR, 32'd13, 64'h0);
        access(1'b1, 32'd13, 64'h44, 64'h0, 1'b0, 64'h0, 4, 1'b0, "write13_from_S");
    endtask

    task automatic test_upgr_convert();
        push_bus(BUS_RD, 32'd2, 64'h0);
        access(1'b0, 32'd2, 64'h0, 64'h55, 1'b1, 64'h55, 4, 1'b0, "read2_shared");
        push_bus(BUS_UPGR, 32'd2, 64'h0);
        push_bus(BUS_RDX, 32'd2, 64'h0);
        access(1'b1, 32'd2, 64'h66, 64'h99, 1'b0, 64'h0, -1, 1'b1, "upgr_to_rdx2");
        probe(32'd2, 1'b1, 1'b1, 64'h66, "line2_M");
    endtask

    task automatic test_reset_mid();
        int cyc;
        cyc = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd7; cpu_wdata = '0;
        while (!bus_req && cyc < 10) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (bus_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_busreq: got bus_req=%b want 1", bus_req);
        end
        rst = 1'b1;
        cpu_req = 1'b0;
        #1;
        checks++;
        if ({bus_req, cpu_resp, cpu_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_mid_outputs: got req=%b resp=%b ready=%b want 0 0 1", bus_req, cpu_resp, cpu_ready);
        end
        probe(32'd13, 1'b0, 1'b0, 64'h0, "reset_mid_line13");
        probe(32'd2, 1'b0, 1'b0, 64'h0, "reset_mid_line2");
`ifdef L1_STATS_EN
        checks++;
        if ({hit_count, miss_count} !== 64'h0) begin
            errors++;
            $display("FAIL reset_mid_stats: got %0d/%0d want 0/0", hit_count, miss_count);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_bus(BUS_RD, 32'd7, 64'h0);
        access(1'b0, 32'd7, 64'h0, 64'h77, 1'b0, 64'h77, 4, 1'b0, "read7_after_reset");
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_cold_and_hit_read();
        test_upgrade();
        test_writeback();
        test_snoop();
        test_upgr_convert();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
